// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack-ISA core with separate req/ack instruction and data memory ports.
// Adds retire pulses, sticky halt-on-self-jump detection, and visibility of the A and D registers.
//
// state   | meaning
// FETCH   | imem_req held until imem_ack; latch IR and the instruction-start A
// MRD     | dmem_re held until dmem_ack; latch M
// EXEC    | ALU, A/D writeback, jump resolve (or hand the result to MWR)
// MWR     | dmem_we held until dmem_ack; then commit pc and retire
// HALT    | self-jump seen; no requests until reset
module hack_cpu_mc #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 15,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              dmem_re,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted,
  output logic [DATA_W-1:0] dbg_a,
  output logic [DATA_W-1:0] dbg_d
);

  typedef enum logic [2:0] {S_FETCH, S_MRD, S_EXEC, S_MWR, S_HALT} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q, npc_q, addr_q;
  logic [DATA_W-1:0]   a_q, d_q, ir_q, m_q, res_q;
  logic                retire_q, halted_q, halt_pend_q;

  logic                is_c;
  logic [DATA_W-1:0]   x0, x1, y0, y1, sum, alu_d;
  logic                zr, ng, take;
  logic                halt_d;
  logic [ADDR_W-1:0]   pc_nxt_d;

  always_comb begin
    is_c  = ir_q[DATA_W-1];
    x0    = ir_q[11] ? '0 : d_q;
    x1    = ir_q[10] ? ~x0 : x0;
    y0    = ir_q[9]  ? '0 : (ir_q[12] ? m_q : a_q);
    y1    = ir_q[8]  ? ~y0 : y0;
    sum   = ir_q[7]  ? (x1 + y1) : (x1 & y1);
    alu_d = ir_q[6]  ? ~sum : sum;
    zr    = (alu_d == '0);
    ng    = alu_d[DATA_W-1];
    take  = is_c & ((ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr));
    // addr_q holds A as it was when the instruction started, i.e. before any d1 write
    halt_d   = is_c && (ir_q[2:0] == 3'b111) && (addr_q == pc_q);
    pc_nxt_d = take ? addr_q : pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      npc_q       <= '0;
      addr_q      <= '0;
      a_q         <= '0;
      d_q         <= '0;
      ir_q        <= '0;
      m_q         <= '0;
      res_q       <= '0;
      retire_q    <= 1'b0;
      halted_q    <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_rdata;
            addr_q  <= a_q[ADDR_W-1:0];
            state_q <= (imem_rdata[DATA_W-1] && imem_rdata[12]) ? S_MRD : S_EXEC;
          end
        end
        S_MRD: begin
          if (dmem_ack) begin
            m_q     <= dmem_rdata;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!is_c) begin
            a_q      <= ir_q;
            pc_q     <= pc_nxt_d;
            retire_q <= 1'b1;
            state_q  <= S_FETCH;
          end else begin
            if (ir_q[5]) a_q <= alu_d;
            if (ir_q[4]) d_q <= alu_d;
            if (ir_q[3]) begin
              res_q       <= alu_d;
              npc_q       <= pc_nxt_d;
              halt_pend_q <= halt_d;
              state_q     <= S_MWR;
            end else begin
              pc_q     <= pc_nxt_d;
              retire_q <= 1'b1;
              halted_q <= halt_d;
              state_q  <= halt_d ? S_HALT : S_FETCH;
            end
          end
        end
        S_MWR: begin
          if (dmem_ack) begin
            pc_q     <= npc_q;
            retire_q <= 1'b1;
            halted_q <= halt_pend_q;
            state_q  <= halt_pend_q ? S_HALT : S_FETCH;
          end
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Reset parks the FSM in FETCH, so the fetch request is masked while reset is held
  assign imem_req   = (state_q == S_FETCH) && reset;
  assign imem_addr  = pc_q;
  assign dmem_re    = (state_q == S_MRD);
  assign dmem_we    = (state_q == S_MWR);
  assign dmem_addr  = addr_q;
  assign dmem_wdata = res_q;
  assign pc         = pc_q;
  assign retire     = retire_q;
  assign halted     = halted_q;
  assign dbg_a      = a_q;
  assign dbg_d      = d_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: ALU vector table, hand-written handshake/jump/halt/reset sequences,
// and random programs with random wait states checked against an instruction-level model.
module tb_hack_cpu_mc;
  localparam int DW = 16;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req, imem_ack = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata = '0;
  logic          dmem_re, dmem_we, dmem_ack = 1'b0;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata = '0;
  logic [AW-1:0] pc;
  logic          retire, halted;
  logic [DW-1:0] dbg_a, dbg_d;

  always #5 clk = ~clk;

  hack_cpu_mc #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire), .halted(halted), .dbg_a(dbg_a), .dbg_d(dbg_d)
  );

  logic [15:0] imem [0:32767];
  logic [15:0] dmem [0:32767];
  logic [15:0] mdm  [0:32767];
  logic [30:0] wlog [$];
  int          rt_q [$];
  int          cyc = 0;
  int          iw_min = 0, iw_max = 0, dw_min = 0, dw_max = 0;
  int          icnt = 0, dcnt = 0;
  bit          ipend = 0, dpend = 0;
  int          n_checks = 0, n_errors = 0;

  // Memory responders: ack raised on the negative edge so it is seen at the next rising edge.
  always @(negedge clk) begin
    if (imem_ack) begin imem_ack = 1'b0; ipend = 0; end
    if (!imem_req) begin ipend = 0; imem_ack = 1'b0; end
    else begin
      if (!ipend) begin ipend = 1; icnt = $urandom_range(iw_max, iw_min); end
      if (icnt == 0) begin imem_ack = 1'b1; imem_rdata = imem[imem_addr]; end
      else icnt--;
    end
  end

  always @(negedge clk) begin
    if (dmem_ack) begin dmem_ack = 1'b0; dpend = 0; end
    if (!(dmem_re || dmem_we)) begin dpend = 0; dmem_ack = 1'b0; end
    else begin
      if (!dpend) begin dpend = 1; dcnt = $urandom_range(dw_max, dw_min); end
      if (dcnt == 0) begin
        dmem_ack = 1'b1;
        if (dmem_we) begin
          dmem[dmem_addr] = dmem_wdata;
          wlog.push_back({dmem_addr, dmem_wdata});
        end else dmem_rdata = dmem[dmem_addr];
      end else dcnt--;
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (retire) rt_q.push_back(cyc);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    rt_q.delete();
    wlog.delete();
    #3 reset = 1'b1;
  endtask

  task automatic run_retires(input int n, input int budget, input string nm);
    int k = 0;
    while (rt_q.size() < n && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk({nm, "_reached"}, 32'(rt_q.size() >= n), 32'd1);
  endtask

  function automatic logic [15:0] ref_alu(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
    case (c)
      6'b101010: return 16'd0;
      6'b111111: return 16'd1;
      6'b111010: return 16'hFFFF;
      6'b001100: return x;
      6'b110000: return y;
      6'b001101: return ~x;
      6'b110001: return ~y;
      6'b001111: return 16'd0 - x;
      6'b110011: return 16'd0 - y;
      6'b011111: return x + 16'd1;
      6'b110111: return y + 16'd1;
      6'b001110: return x - 16'd1;
      6'b110010: return y - 16'd1;
      6'b000010: return x + y;
      6'b010011: return x - y;
      6'b000111: return y - x;
      6'b000000: return x & y;
      6'b010101: return x | y;
      default:   return 16'd0;
    endcase
  endfunction

  logic [5:0] comps [18];

  function automatic logic [15:0] rnd_ins();
    logic [5:0] c;
    logic       a;
    logic [2:0] dst, j;
    if ($urandom_range(99, 0) < 40) return {1'b0, 15'($urandom_range(63, 0))};
    c   = comps[$urandom_range(17, 0)];
    a   = 1'($urandom_range(1, 0));
    dst = 3'($urandom_range(7, 0));
    j   = ($urandom_range(9, 0) < 6) ? 3'd0 : 3'($urandom_range(7, 1));
    return {3'b111, a, c, dst, j};
  endfunction

  typedef struct {
    logic [14:0] x;
    logic [14:0] y;
    logic [5:0]  c;
    logic [15:0] e;
  } vec_t;
  vec_t tbl [16];

  logic [14:0] mpc;
  logic [15:0] ma, md;
  bit          mh;

  task automatic model_step(input int p);
    logic [15:0] ins, x, y, o, oa;
    logic        neg, zer, tk;
    logic [30:0] w;
    ins = imem[mpc];
    if (!ins[15]) begin
      ma  = ins;
      mpc = mpc + 15'd1;
    end else begin
      x  = md;
      y  = ins[12] ? mdm[ma[14:0]] : ma;
      o  = ref_alu(ins[11:6], x, y);
      oa = ma;
      if (ins[3]) begin
        mdm[oa[14:0]] = o;
        if (wlog.size() == 0) chk($sformatf("rnd%0d_wr_present", p), 32'd0, 32'd1);
        else begin
          w = wlog.pop_front();
          chk($sformatf("rnd%0d_wr_addr_data", p), 32'(w), 32'({oa[14:0], o}));
        end
      end else chk($sformatf("rnd%0d_no_wr", p), 32'(wlog.size()), 32'd0);
      if (ins[5]) ma = o;
      if (ins[4]) md = o;
      neg = $signed(o) < 0;
      zer = (o == 16'd0);
      tk  = (ins[2] && neg) || (ins[1] && zer) || (ins[0] && !neg && !zer);
      if (ins[2:0] == 3'b111 && oa[14:0] == mpc) mh = 1;
      else mpc = tk ? oa[14:0] : mpc + 15'd1;
    end
  endtask

  initial begin
    int n;
    int we_any, we_ok, busy;
    comps = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
              6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
              6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};
    tbl[0]  = '{15'd7,      15'd3,      6'b000010, 16'h000A};
    tbl[1]  = '{15'd3,      15'd7,      6'b010011, 16'hFFFC};
    tbl[2]  = '{15'd3,      15'd7,      6'b000111, 16'h0004};
    tbl[3]  = '{15'h0F0F,   15'h00FF,   6'b000000, 16'h000F};
    tbl[4]  = '{15'h0F00,   15'h00F0,   6'b010101, 16'h0FF0};
    tbl[5]  = '{15'd0,      15'd9,      6'b001101, 16'hFFFF};
    tbl[6]  = '{15'd5,      15'd1,      6'b110011, 16'hFFFF};
    tbl[7]  = '{15'h7FFF,   15'd0,      6'b011111, 16'h8000};
    tbl[8]  = '{15'd4,      15'd0,      6'b110010, 16'hFFFF};
    tbl[9]  = '{15'd4,      15'd2,      6'b111111, 16'h0001};
    tbl[10] = '{15'h1234,   15'h0F0F,   6'b110001, 16'hF0F0};
    tbl[11] = '{15'd5,      15'd6,      6'b001110, 16'h0004};
    tbl[12] = '{15'h4000,   15'h4000,   6'b000010, 16'h8000};
    tbl[13] = '{15'h7FFF,   15'h7FFF,   6'b000010, 16'hFFFE};
    tbl[14] = '{15'd9,      15'd2,      6'b101010, 16'h0000};
    tbl[15] = '{15'h7FFF,   15'd1,      6'b001111, 16'h8001};
    for (int i = 0; i < 32768; i++) begin imem[i] = '0; dmem[i] = '0; mdm[i] = '0; end

    // reset state
    #12;
    chk("rst_req_lines", {29'd0, imem_req, dmem_re, dmem_we}, 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_retire_halted", {30'd0, retire, halted}, 32'd0);
    chk("rst_a_d", {dbg_a, dbg_d}, 32'd0);

    // 1: zero-wait @5; D=A
    imem[0] = 16'h0005; imem[1] = 16'hEC10;
    do_reset();
    repeat (4) @(posedge clk);
    #2;
    chk("t1_retires", 32'(rt_q.size()), 32'd2);
    chk("t1_d", 32'(dbg_d), 32'd5);
    chk("t1_pc", 32'(pc), 32'd2);

    // 2: instruction ack delayed by 3 cycles
    iw_min = 3; iw_max = 3;
    imem[0] = 16'h0005;
    do_reset();
    #1;
    chk("t2_hold0", {29'd0, imem_req, imem_addr == 15'd0, retire}, 32'b110);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t2_hold%0d", i), {29'd0, imem_req, imem_addr == 15'd0, retire}, 32'b110);
    end
    @(posedge clk); #1;
    chk("t2_req_dropped", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    chk("t2_retire_a", {15'd0, retire, dbg_a}, {15'd0, 1'b1, 16'd5});
    iw_min = 0; iw_max = 0;

    // 3: M=D+1 with A=100, D=7; first with two data wait states, then zero-wait
    imem[0] = 16'h0007; imem[1] = 16'hEC10; imem[2] = 16'h0064; imem[3] = 16'hE7C8;
    for (int pass = 0; pass < 2; pass++) begin
      dw_min = (pass == 0) ? 2 : 0; dw_max = dw_min;
      dmem[100] = 16'h0000;
      do_reset();
      run_retires(3, 40, "t3_pre");
      we_any = 0; we_ok = 0; n = 0;
      while (rt_q.size() < 4 && n < 12) begin
        @(posedge clk); #2; n++;
        if (dmem_we) begin
          we_any++;
          if (dmem_addr == 15'd100 && dmem_wdata == 16'd8 && !dmem_re) we_ok++;
        end
      end
      chk($sformatf("t3_p%0d_we_cycles", pass), 32'(we_any), 32'(1 + dw_min));
      chk($sformatf("t3_p%0d_we_held_ok", pass), 32'(we_ok), 32'(1 + dw_min));
      chk($sformatf("t3_p%0d_mem", pass), 32'(dmem[100]), 32'd8);
      if (rt_q.size() == 4)
        chk($sformatf("t3_p%0d_latency", pass), 32'(rt_q[3] - rt_q[2]), 32'(3 + dw_min));
      else
        chk($sformatf("t3_p%0d_retired", pass), 32'(rt_q.size()), 32'd4);
      chk($sformatf("t3_p%0d_d", pass), 32'(dbg_d), 32'd7);
    end
    dw_min = 0; dw_max = 0;

    // ALU vector table: @x; D=A; @y; D=comp
    iw_max = 1;
    for (int i = 0; i < 16; i++) begin
      imem[0] = {1'b0, tbl[i].x};
      imem[1] = 16'hEC10;
      imem[2] = {1'b0, tbl[i].y};
      imem[3] = {3'b111, 1'b0, tbl[i].c, 3'b010, 3'b000};
      do_reset();
      run_retires(4, 60, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_d", i), 32'(dbg_d), 32'(tbl[i].e));
      chk($sformatf("vec%0d_a", i), 32'(dbg_a), 32'({1'b0, tbl[i].y}));
    end
    iw_max = 0;

    // 4: D;JGT not taken with D=-1, taken with D=3, and pc wrap at 0x7FFF
    imem[0] = 16'hEE90; imem[1] = 16'h0014; imem[2] = 16'hE301;
    do_reset();
    run_retires(3, 40, "t4a");
    chk("t4a_pc", 32'(pc), 32'd3);
    imem[0] = 16'h0003; imem[1] = 16'hEC10; imem[2] = 16'h0014; imem[3] = 16'hE301;
    do_reset();
    run_retires(4, 40, "t4b");
    chk("t4b_pc", 32'(pc), 32'd20);
    imem[0] = 16'h7FFF; imem[1] = 16'hEA87; imem[32767] = 16'hE301;
    do_reset();
    run_retires(2, 40, "t4c_jmp");
    chk("t4c_pc_top", 32'(pc), 32'h7FFF);
    run_retires(3, 40, "t4c_wrap");
    chk("t4c_pc_wrap", {31'(pc), halted}, 32'd0);

    // 5: @1; 0;JMP at address 1 halts
    imem[0] = 16'h0001; imem[1] = 16'hEA87;
    do_reset();
    run_retires(2, 40, "t5");
    chk("t5_halted_pc", {15'd0, halted, 16'(pc)}, {15'd0, 1'b1, 16'd1});
    busy = 0;
    repeat (20) begin
      @(posedge clk); #2;
      if (imem_req || dmem_re || dmem_we) busy++;
    end
    chk("t5_idle_cycles_busy", 32'(busy), 32'd0);
    chk("t5_no_more_retire", 32'(rt_q.size()), 32'd2);

    // 6: reset asserted while a write waits for ack
    imem[0] = 16'h0064; imem[1] = 16'hE7C8;
    dmem[100] = 16'h1111;
    dw_min = 10; dw_max = 10;
    do_reset();
    n = 0;
    while (!dmem_we && n < 30) begin @(posedge clk); #2; n++; end
    chk("t6_in_mwr", 32'(dmem_we), 32'd1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("t6_abort", {15'd0, dmem_we, imem_req, 15'(pc)}, 32'd0);
    dw_min = 0; dw_max = 0;
    @(posedge clk); #3;
    rt_q.delete(); wlog.delete();
    reset = 1'b1;
    #1;
    chk("t6_refetch", {16'd0, imem_req, 15'(imem_addr)}, {16'd0, 1'b1, 15'd0});
    run_retires(1, 20, "t6_resume");
    chk("t6_pc_a", {1'b0, 15'(pc), dbg_a}, {1'b0, 15'd1, 16'd100});
    chk("t6_mem_untouched", 32'(dmem[100]), 32'h1111);

    // random programs with random wait states against the instruction-level model
    iw_min = 0; iw_max = 2; dw_min = 0; dw_max = 2;
    for (int p = 0; p < 4; p++) begin
      int nret, k, both;
      for (int i = 0; i < 32768; i++) imem[i] = rnd_ins();
      for (int i = 0; i < 64; i++) begin dmem[i] = 16'($urandom); mdm[i] = dmem[i]; end
      for (int i = 64; i < 32768; i++) mdm[i] = dmem[i];
      do_reset();
      mpc = '0; ma = '0; md = '0; mh = 0;
      nret = 0; k = 0; both = 0;
      while (nret < 250 && !mh && k < 8000) begin
        @(posedge clk); #3; k++;
        if (dmem_re && dmem_we) both++;
        if (retire) begin
          model_step(p);
          nret++;
          chk($sformatf("rnd%0d_r%0d_pc", p, nret), 32'(pc), 32'(mpc));
          chk($sformatf("rnd%0d_r%0d_ad", p, nret), {dbg_a, dbg_d}, {ma, md});
          chk($sformatf("rnd%0d_r%0d_halt", p, nret), 32'(halted), 32'(mh));
        end
      end
      chk($sformatf("rnd%0d_progress", p), 32'(nret >= 250 || mh), 32'd1);
      chk($sformatf("rnd%0d_re_we_overlap", p), 32'(both), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
